// File: rtl/motor_pwm_pkg.sv
// Shared widths, the width type and the target saturation helper for the multi-channel pulse generator.
package motor_pwm_pkg;
  localparam int CNT_W_DEF = 21;
  localparam int SPD_W_DEF = 8;
  localparam int SCL_W_DEF = 8;
  localparam int CALC_W    = 48;

  typedef logic [CNT_W_DEF-1:0] width_t;

  // Clamp a signed width to [0, hi].
  function automatic logic [CALC_W-1:0] sat_width(input logic signed [CALC_W-1:0] v,
                                                   input logic [CALC_W-1:0] hi);
    if (v < 0) return '0;
    if ($unsigned(v) > hi) return hi;
    return $unsigned(v);
  endfunction
endpackage

// File: rtl/motor_pwm_multi_if.sv
// Speed command channel: one command per valid&&ready, addressed to a motor channel.
interface motor_pwm_multi_if #(
  parameter int N_CH  = 4,
  parameter int SPD_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [CH_W-1:0]  cmd_ch;
  logic             cmd_dir;
  logic [SPD_W-1:0] cmd_spd;

  modport master (output cmd_valid, cmd_ch, cmd_dir, cmd_spd, input cmd_ready);
  modport slave  (input cmd_valid, cmd_ch, cmd_dir, cmd_spd, output cmd_ready);
endinterface

// File: rtl/pwm_ramp_ch.sv
// One motor channel: target register, once-per-frame slew toward it, and registered pulse compare.
module pwm_ramp_ch #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             wrap,
  input  logic             tgt_we,
  input  logic             stop,
  input  logic [CNT_W-1:0] tgt_new,
  input  logic [CNT_W-1:0] period_stopped,
  input  logic [CNT_W-1:0] ramp_step,
  input  logic [CNT_W-1:0] cnt,
  output logic             pwm,
  output logic             motor_en
);
  logic [CNT_W-1:0] target, width, diff, step, width_nx;

  always_comb begin
    diff     = (width < target) ? target - width : width - target;
    step     = (ramp_step == '0 || ramp_step > diff) ? diff : ramp_step;
    width_nx = (width < target) ? width + step : width - step;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      target   <= period_stopped;
      width    <= period_stopped;
      pwm      <= 1'b0;
      motor_en <= 1'b0;
    end else begin
      // A fresh command outranks the watchdog safe-stop.
      if (tgt_we)    target <= tgt_new;
      else if (stop) target <= period_stopped;
      if (!en)       width  <= period_stopped;
      else if (wrap) width  <= width_nx;
      pwm      <= en && (cnt < width);
      motor_en <= en && (width != period_stopped);
    end
  end
endmodule

// File: rtl/motor_pwm_multi.sv
// N-channel ESC/servo pulse generator: frame counter, command decode to saturated targets, and
// command watchdog; per-channel ramp and compare live in pwm_ramp_ch.
module motor_pwm_multi
  import motor_pwm_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SPD_W       = SPD_W_DEF,
  parameter int SCL_W       = SCL_W_DEF,
  parameter int WDOG_FRAMES = 25
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] frame_len,
  input  logic [CNT_W-1:0] period_stopped,
  input  logic [SCL_W-1:0] spd_scaling,
  input  logic [CNT_W-1:0] ramp_step,
  motor_pwm_multi_if.slave cmd,
  output logic [N_CH-1:0]  pwm_out,
  output logic [N_CH-1:0]  motor_en,
  output logic             frame_start,
  output logic             wdog_tripped
);
  localparam int PRD_W = SCL_W + SPD_W;
  localparam int WD_W  = $clog2(WDOG_FRAMES + 2);

  logic [CNT_W-1:0]         cnt, frame_len_r, len_clamp, tgt_new;
  logic [PRD_W-1:0]         prod;
  logic signed [CALC_W-1:0] tgt_raw;
  logic [N_CH-1:0]          tgt_we;
  logic [WD_W-1:0]          wd_cnt;
  logic                     ready_q, accept, wrap, trip;

  assign cmd.cmd_ready = ready_q;
  assign accept        = cmd.cmd_valid && ready_q;
  assign len_clamp     = (frame_len < CNT_W'(2)) ? CNT_W'(2) : frame_len;
  assign wrap          = en && (cnt == frame_len_r - CNT_W'(1));

  assign prod    = PRD_W'(spd_scaling) * PRD_W'(cmd.cmd_spd);
  assign tgt_raw = cmd.cmd_dir ? $signed(CALC_W'(period_stopped)) - $signed(CALC_W'(prod))
                               : $signed(CALC_W'(period_stopped)) + $signed(CALC_W'(prod));
  assign tgt_new = CNT_W'(sat_width(tgt_raw, CALC_W'(frame_len_r)));

  // Out-of-range channel numbers match no lane and are silently dropped.
  always_comb begin
    tgt_we = '0;
    for (int i = 0; i < N_CH; i++)
      tgt_we[i] = accept && (int'(cmd.cmd_ch) == i);
  end

  // Length tracks the input while idle so an enable starts with the current frame length.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      frame_len_r <= len_clamp;
      frame_start <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      ready_q     <= 1'b1;
      frame_start <= en && (cnt == '0);
      if (!en || wrap) begin
        cnt         <= '0;
        frame_len_r <= len_clamp;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign trip = (WDOG_FRAMES != 0) && wrap && !accept && !wdog_tripped &&
                (wd_cnt == WD_W'(WDOG_FRAMES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt       <= '0;
      wdog_tripped <= 1'b0;
    end else if (accept) begin
      wd_cnt       <= '0;
      wdog_tripped <= 1'b0;
    end else if (wrap && (WDOG_FRAMES != 0) && !wdog_tripped) begin
      wd_cnt <= wd_cnt + WD_W'(1);
      if (trip) wdog_tripped <= 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    pwm_ramp_ch #(.CNT_W(CNT_W)) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .wrap           (wrap),
      .tgt_we         (tgt_we[g]),
      .stop           (trip),
      .tgt_new        (tgt_new),
      .period_stopped (period_stopped),
      .ramp_step      (ramp_step),
      .cnt            (cnt),
      .pwm            (pwm_out[g]),
      .motor_en       (motor_en[g])
    );
  end
endmodule

// File: tb/tb_motor_pwm_multi.sv
// Directed bench for motor_pwm_multi: command table plus ramp, watchdog, wrap-cycle and en/reset sequences.
module tb_motor_pwm_multi;
  import motor_pwm_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, en;
  width_t     frame_len, period_stopped, ramp_step;
  logic [7:0] spd_scaling;
  logic [3:0] pwm_out, motor_en;
  logic       frame_start, wdog_tripped;

  int         tests = 0, fails = 0;
  int         f_len;
  int         f_hi[4];
  logic [3:0] f_men;
  logic       f_trip;

  typedef struct {
    int ch;
    int dir;
    int spd;
    int hi[4];
    int men;
  } vec_t;
  vec_t vecs[8];

  motor_pwm_multi_if #(.N_CH(4), .SPD_W(8)) cmd_if ();

  motor_pwm_multi #(.N_CH(4), .CNT_W(21), .SPD_W(8), .SCL_W(8), .WDOG_FRAMES(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .frame_len      (frame_len),
    .period_stopped (period_stopped),
    .spd_scaling    (spd_scaling),
    .ramp_step      (ramp_step),
    .cmd            (cmd_if),
    .pwm_out        (pwm_out),
    .motor_en       (motor_en),
    .frame_start    (frame_start),
    .wdog_tripped   (wdog_tripped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sync();
    int n = 0;
    while (!frame_start && n < 400) begin
      tick();
      n++;
    end
    chk("sync_frame_start", int'(frame_start), 1);
  endtask

  task automatic send(int ch, int dir, int spd);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_ch    = 2'(ch);
    cmd_if.cmd_dir   = 1'(dir);
    cmd_if.cmd_spd   = 8'(spd);
    tick();
    cmd_if.cmd_valid = 1'b0;
  endtask

  // Entered on a frame_start sample; collects one whole frame, returns on the next frame_start.
  task automatic frame();
    f_men  = motor_en;
    f_trip = wdog_tripped;
    f_len  = 0;
    for (int c = 0; c < 4; c++) f_hi[c] = 0;
    do begin
      for (int c = 0; c < 4; c++) f_hi[c] += int'(pwm_out[c]);
      tick();
      f_len++;
    end while (!frame_start && f_len < 400);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{1, 0, 10,  '{50, 70, 50, 50},  4'b0010};
    vecs[1] = '{2, 1, 40,  '{50, 70, 0, 50},   4'b0110};
    vecs[2] = '{0, 0, 200, '{100, 70, 0, 50},  4'b0111};
    vecs[3] = '{3, 1, 25,  '{100, 70, 0, 0},   4'b1111};
    vecs[4] = '{1, 1, 0,   '{100, 50, 0, 0},   4'b1101};
    vecs[5] = '{3, 0, 24,  '{100, 50, 0, 98},  4'b1101};
    vecs[6] = '{2, 0, 0,   '{100, 50, 50, 98}, 4'b1001};
    vecs[7] = '{0, 1, 255, '{0, 50, 50, 98},   4'b1001};

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_ch    = '0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_spd   = '0;
    rst_n = 1'b0; en = 1'b1;
    frame_len = 100; period_stopped = 50; spd_scaling = 2; ramp_step = 0;

    tick();
    tick();
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_motor_en", int'(motor_en), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_wdog", int'(wdog_tripped), 0);
    chk("rst_cmd_ready", int'(cmd_if.cmd_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", int'(cmd_if.cmd_ready), 1);

    // Immediate (ramp_step=0) command table, cumulative channel state.
    for (int r = 0; r < 8; r++) begin
      sync();
      send(vecs[r].ch, vecs[r].dir, vecs[r].spd);
      sync();
      frame();
      for (int c = 0; c < 4; c++)
        chk($sformatf("tbl%0d_hi_ch%0d", r, c), f_hi[c], vecs[r].hi[c]);
      chk($sformatf("tbl%0d_motor_en", r), int'(f_men), vecs[r].men);
    end

    // Slew: ch0 to 90 in steps of 5; command held so the watchdog stays fed.
    ramp_step = 5;
    do_reset();
    sync();
    cmd_if.cmd_valid = 1'b1; cmd_if.cmd_ch = 2'd0; cmd_if.cmd_dir = 1'b0; cmd_if.cmd_spd = 8'd20;
    tick();
    sync();
    for (int k = 0; k < 9; k++) begin
      frame();
      chk($sformatf("ramp%0d_ch0", k), f_hi[0], (k < 7) ? 55 + 5 * k : 90);
      chk($sformatf("ramp%0d_ch1", k), f_hi[1], 50);
      chk($sformatf("ramp%0d_men", k), int'(f_men), 1);
    end
    cmd_if.cmd_valid = 1'b0;

    // Watchdog: trip on the 3rd silent wrap, width returns to stopped one wrap later.
    ramp_step = 0;
    do_reset();
    sync();
    send(3, 0, 10);
    sync();
    for (int k = 0; k < 4; k++) begin
      frame();
      chk($sformatf("wd%0d_ch3", k), f_hi[3], (k < 3) ? 70 : 50);
      chk($sformatf("wd%0d_men3", k), int'(f_men[3]), (k < 3) ? 1 : 0);
      chk($sformatf("wd%0d_trip", k), int'(f_trip), (k >= 2) ? 1 : 0);
    end
    chk("wd_held", int'(wdog_tripped), 1);
    send(1, 0, 5);
    chk("wd_clear_on_accept", int'(wdog_tripped), 0);

    // Command accepted on the wrap edge and a mid-frame length change.
    sync();
    repeat (50) tick();
    frame_len = 60;
    repeat (48) tick();
    send(0, 0, 10);
    chk("wrapcmd_no_early_start", int'(frame_start), 0);
    tick();
    chk("old_len_kept", int'(frame_start), 1);
    frame();
    chk("len60_a", f_len, 60);
    chk("wrapcmd_old_target", f_hi[0], 50);
    chk("wrapcmd_ch1", f_hi[1], 60);
    frame();
    chk("len60_b", f_len, 60);
    chk("wrapcmd_new_target", f_hi[0], 60);

    // en dropped mid-pulse, then restarted at a new length.
    send(0, 0, 10);
    chk("pre_en_low_pwm0", int'(pwm_out[0]), 1);
    en = 1'b0;
    tick();
    chk("en_low_pwm", int'(pwm_out), 0);
    chk("en_low_men", int'(motor_en), 0);
    chk("en_low_fs", int'(frame_start), 0);
    chk("en_low_ready", int'(cmd_if.cmd_ready), 1);
    frame_len = 100;
    repeat (3) tick();
    chk("en_low_pwm_hold", int'(pwm_out), 0);
    en = 1'b1;
    tick();
    chk("en_rise_fs", int'(frame_start), 1);
    chk("en_rise_pwm", int'(pwm_out), 4'hF);
    frame();
    chk("en_rise_len", f_len, 100);
    chk("en_rise_ch0_stopped", f_hi[0], 50);
    chk("en_rise_men", int'(f_men), 0);
    frame();
    chk("en_ramp_ch0", f_hi[0], 60);
    chk("en_ramp_ch1", f_hi[1], 60);
    chk("en_ramp_ch2", f_hi[2], 50);
    chk("en_ramp_men", int'(f_men), 4'b0011);

    // Reset in mid-frame.
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_pwm", int'(pwm_out), 0);
    chk("midrst_men", int'(motor_en), 0);
    chk("midrst_fs", int'(frame_start), 0);
    chk("midrst_ready", int'(cmd_if.cmd_ready), 0);
    rst_n = 1'b1;
    tick();
    chk("postrst_fs", int'(frame_start), 1);
    frame();
    chk("postrst_len", f_len, 100);
    chk("postrst_ch0", f_hi[0], 50);
    chk("postrst_ch1", f_hi[1], 50);
    chk("postrst_men", int'(f_men), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
